// File: rtl/param_data_path.sv
// K&S core datapath: IR, PC, register file, 4-function ALU and flags, sequenced
// entirely by the external control unit through enable/select strobes.

typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO, I_HALT
} decoded_instruction_type;

module param_data_path #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [1:0]              operation,
    input  logic                    write_reg_enable,
    input  logic                    flags_reg_enable,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       data_out,
    input  logic [DATA_W-1:0]       data_in
);

    localparam int RSW = $clog2(NREGS);
    localparam int MSB = DATA_W - 1;

    if (DATA_W < 16 || NREGS < 2 || (1 << RSW) != NREGS ||
        3 * RSW > 8 || ADDR_W + RSW > 8) begin : g_bad_params
        $error("param_data_path: illegal parameter combination");
    end

    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] regs [NREGS];

    logic [7:0]        opcode;
    logic              use_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic [RSW-1:0]    sel_a, sel_b, sel_c;
    logic [DATA_W-1:0] bus_a, bus_b, bus_c;

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_res;
    logic              alu_uov, alu_sov, alu_zero, alu_neg;

    // Only the opcode byte and low field bits are decoded; the rest of IR is ignored.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir;

    assign opcode = ir[DATA_W-1:DATA_W-8];

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        decoded_instruction = I_NOP;
        use_addr            = 1'b0;
        sel_a               = '0;
        sel_b               = '0;
        sel_c               = '0;
        case (opcode)
            8'h81: begin
                decoded_instruction = I_LOAD;
                use_addr            = 1'b1;
                sel_c               = ir[ADDR_W+RSW-1:ADDR_W];
            end
            8'h82: begin
                decoded_instruction = I_STORE;
                use_addr            = 1'b1;
                sel_a               = ir[ADDR_W+RSW-1:ADDR_W];
            end
            8'h91: begin
                decoded_instruction = I_MOVE;
                sel_c               = ir[2*RSW-1:RSW];
                sel_a               = ir[RSW-1:0];
                sel_b               = ir[RSW-1:0];
            end
            8'hA1, 8'hA2, 8'hA3, 8'hA4: begin
                case (opcode[2:0])
                    3'd1:    decoded_instruction = I_ADD;
                    3'd2:    decoded_instruction = I_SUB;
                    3'd3:    decoded_instruction = I_AND;
                    default: decoded_instruction = I_OR;
                endcase
                sel_a = ir[RSW-1:0];
                sel_b = ir[2*RSW-1:RSW];
                sel_c = ir[3*RSW-1:2*RSW];
            end
            8'h01: begin decoded_instruction = I_BRANCH; use_addr = 1'b1; end
            8'h02: begin decoded_instruction = I_BZERO;  use_addr = 1'b1; end
            8'h03: begin decoded_instruction = I_BNEG;   use_addr = 1'b1; end
            8'h05: begin decoded_instruction = I_BOV;    use_addr = 1'b1; end
            8'h06: begin decoded_instruction = I_BNOV;   use_addr = 1'b1; end
            8'h0A: begin decoded_instruction = I_BNNEG;  use_addr = 1'b1; end
            8'h0B: begin decoded_instruction = I_BNZERO; use_addr = 1'b1; end
            8'hFF: decoded_instruction = I_HALT;
            default: ;
        endcase
    end

    assign mem_addr = use_addr ? ir[ADDR_W-1:0] : '0;
    assign bus_a    = regs[sel_a];
    assign bus_b    = regs[sel_b];
    assign bus_c    = c_sel ? alu_res : data_in;
    assign ram_addr = addr_sel ? mem_addr : pc;
    assign data_out = bus_a;

    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_uov = 1'b0;
        alu_sov = 1'b0;
        case (operation)
            2'b00: begin
                sum     = {1'b0, bus_a} + {1'b0, bus_b};
                alu_res = sum[DATA_W-1:0];
                alu_uov = sum[DATA_W];
                // Carry into the MSB is recovered from the MSB sum bit.
                alu_sov = (bus_a[MSB] ^ bus_b[MSB] ^ sum[MSB]) ^ sum[DATA_W];
            end
            2'b01: begin
                sum     = {1'b0, bus_a} + {1'b0, ~bus_b} + (DATA_W + 1)'(1);
                alu_res = sum[DATA_W-1:0];
                alu_uov = bus_a < bus_b;
                alu_sov = (bus_a[MSB] != bus_b[MSB]) && (sum[MSB] != bus_a[MSB]);
            end
            2'b10:   alu_res = bus_a & bus_b;
            default: alu_res = bus_a | bus_b;
        endcase
    end

    assign alu_zero = (alu_res == '0);
    assign alu_neg  = alu_res[MSB];

    // NOTE: sequential state is assigned with non-blocking <= so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc                <= '0;
            ir                <= '0;
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
        end else begin
            if (pc_enable)
                pc <= branch ? mem_addr : pc + ADDR_W'(1);
            if (ir_enable)
                ir <= data_in;
            if (flags_reg_enable) begin
                zero_op           <= alu_zero;
                neg_op            <= alu_neg;
                unsigned_overflow <= alu_uov;
                signed_overflow   <= alu_sov;
            end
        end
    end

    // NOTE: the register file is architectural state that must read 0 after reset,
    // so it is built from resettable flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (write_reg_enable) begin
            regs[sel_c] <= bus_c;
        end
    end

endmodule

// File: tb/tb_param_data_path.sv
// Directed self-checking bench for param_data_path with the default parameters.

module tb_param_data_path;

    localparam logic [3:0] D_NOP = 4'd0, D_LOAD = 4'd1, D_STORE = 4'd2, D_MOVE = 4'd3,
                           D_ADD = 4'd4, D_SUB = 4'd5, D_AND = 4'd6, D_OR = 4'd7,
                           D_BRANCH = 4'd8, D_BZERO = 4'd9, D_BNEG = 4'd10, D_BOV = 4'd11,
                           D_BNOV = 4'd12, D_BNNEG = 4'd13, D_BNZERO = 4'd14, D_HALT = 4'd15;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch, pc_enable, ir_enable, addr_sel, c_sel;
    logic [1:0]  operation;
    logic        write_reg_enable, flags_reg_enable;
    logic [3:0]  decoded;
    logic        zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic [4:0]  ram_addr;
    logic [15:0] data_out, data_in;
    logic [15:0] rd;

    int errors = 0;
    int checks = 0;

    param_data_path dut (
        .clk                 (clk),
        .rst                 (rst),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .write_reg_enable    (write_reg_enable),
        .flags_reg_enable    (flags_reg_enable),
        .decoded_instruction (decoded),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .ram_addr            (ram_addr),
        .data_out            (data_out),
        .data_in             (data_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [15:0] v);
        data_in   = v;
        ir_enable = 1'b1;
        step();
        ir_enable = 1'b0;
    endtask

    task automatic load_reg(input logic [1:0] r, input logic [15:0] v);
        load_ir({8'h81, 1'b0, r, 5'h10});
        data_in          = v;
        c_sel            = 1'b0;
        write_reg_enable = 1'b1;
        step();
        write_reg_enable = 1'b0;
    endtask

    // Reads a register through data_out by decoding a STORE of it.
    task automatic read_reg(input logic [1:0] r, output logic [15:0] v);
        load_ir({8'h82, 1'b0, r, 5'h00});
        v = data_out;
    endtask

    task automatic alu(input logic [7:0] opc, input logic [1:0] op, input logic [1:0] a,
                       input logic [1:0] b, input logic [1:0] c, input logic fl);
        load_ir({opc, 2'b00, c, b, a});
        operation        = op;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        flags_reg_enable = fl;
        step();
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        c_sel            = 1'b0;
    endtask

    function automatic logic [3:0] flags();
        return {zero_op, neg_op, unsigned_overflow, signed_overflow};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    logic [7:0] dec_opc [19] = '{8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h01, 8'h02, 8'h03,
                                 8'h05, 8'h06, 8'h0A, 8'h0B, 8'hFF, 8'h00, 8'h04, 8'h80, 8'hA5};
    logic [3:0] dec_exp [19] = '{D_LOAD, D_STORE, D_MOVE, D_ADD, D_SUB, D_AND, D_OR, D_BRANCH,
                                 D_BZERO, D_BNEG, D_BOV, D_BNOV, D_BNNEG, D_BNZERO, D_HALT,
                                 D_NOP, D_NOP, D_NOP, D_NOP};

    initial begin
        rst = 1'b1;
        {branch, pc_enable, ir_enable, addr_sel, c_sel} = '0;
        operation = 2'b00;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        data_in = 16'h0000;
        #12;
        check("reset ram_addr", ram_addr, 5'h00);
        check("reset data_out", data_out, 16'h0000);
        check("reset decode", decoded, D_NOP);
        check("reset flags", flags(), 4'b0000);
        rst = 1'b0;
        step();

        // LOAD then ADD with signed overflow
        load_ir(16'h8130);
        addr_sel = 1'b1;
        #1;
        check("load ram_addr", ram_addr, 5'h10);
        check("load decode", decoded, D_LOAD);
        addr_sel = 1'b0;
        data_in = 16'h7FFF;
        c_sel = 1'b0;
        write_reg_enable = 1'b1;
        step();
        write_reg_enable = 1'b0;
        load_reg(2'd2, 16'h0001);
        alu(8'hA1, 2'b00, 2'd1, 2'd2, 2'd3, 1'b1);
        check("add 7fff+1 flags", flags(), 4'b0101);
        read_reg(2'd1, rd); check("R1 loaded", rd, 16'h7FFF);
        read_reg(2'd3, rd); check("add 7fff+1 result", rd, 16'h8000);

        // SUB with borrow, then equal operands
        load_reg(2'd1, 16'd3);
        load_reg(2'd2, 16'd5);
        alu(8'hA2, 2'b01, 2'd1, 2'd2, 2'd3, 1'b1);
        check("sub 3-5 flags", flags(), 4'b0110);
        read_reg(2'd3, rd); check("sub 3-5 result", rd, 16'hFFFE);
        load_reg(2'd1, 16'd5);
        alu(8'hA2, 2'b01, 2'd1, 2'd2, 2'd3, 1'b1);
        check("sub 5-5 flags", flags(), 4'b1000);
        read_reg(2'd3, rd); check("sub 5-5 result", rd, 16'h0000);

        // Unsigned carry on add, signed overflow on sub
        load_reg(2'd1, 16'hFFFF);
        load_reg(2'd2, 16'h0001);
        alu(8'hA1, 2'b00, 2'd1, 2'd2, 2'd3, 1'b1);
        check("add ffff+1 flags", flags(), 4'b1010);
        load_reg(2'd1, 16'h8000);
        alu(8'hA2, 2'b01, 2'd1, 2'd2, 2'd3, 1'b1);
        check("sub 8000-1 flags", flags(), 4'b0001);
        read_reg(2'd3, rd); check("sub 8000-1 result", rd, 16'h7FFF);

        // AND/OR, and an ALU op with flag capture disabled
        load_reg(2'd1, 16'hF0F0);
        load_reg(2'd2, 16'hFF00);
        alu(8'hA3, 2'b10, 2'd1, 2'd2, 2'd3, 1'b1);
        check("and flags", flags(), 4'b0100);
        read_reg(2'd3, rd); check("and result", rd, 16'hF000);
        alu(8'hA2, 2'b01, 2'd1, 2'd2, 2'd3, 1'b0);
        check("flags held", flags(), 4'b0100);
        read_reg(2'd3, rd); check("sub no-flags result", rd, 16'hF1F0);
        alu(8'hA4, 2'b11, 2'd1, 2'd2, 2'd0, 1'b1);
        check("or flags", flags(), 4'b0100);
        read_reg(2'd0, rd); check("or result", rd, 16'hFFF0);

        // STORE and MOVE
        load_reg(2'd2, 16'hBEEF);
        load_ir(16'h8255);
        addr_sel = 1'b1;
        #1;
        check("store ram_addr", ram_addr, 5'h15);
        check("store data_out", data_out, 16'hBEEF);
        addr_sel = 1'b0;
        load_ir(16'h9106);
        check("move decode", decoded, D_MOVE);
        operation = 2'b11;
        c_sel = 1'b1;
        write_reg_enable = 1'b1;
        step();
        write_reg_enable = 1'b0;
        c_sel = 1'b0;
        read_reg(2'd1, rd); check("move result", rd, 16'hBEEF);

        // PC increment, wrap and branch
        check("pc start", ram_addr, 5'd0);
        pc_enable = 1'b1;
        branch = 1'b0;
        repeat (31) step();
        check("pc 31", ram_addr, 5'd31);
        step();
        check("pc wrap", ram_addr, 5'd0);
        pc_enable = 1'b0;
        load_ir(16'h0114);
        check("branch decode", decoded, D_BRANCH);
        branch = 1'b1;
        pc_enable = 1'b1;
        step();
        pc_enable = 1'b0;
        branch = 1'b0;
        check("branch target", ram_addr, 5'h14);

        for (int i = 0; i < 19; i++) begin
            load_ir({dec_opc[i], 8'h00});
            check($sformatf("decode %02h", dec_opc[i]), decoded, dec_exp[i]);
        end

        // Simultaneous IR load with register write uses the old decode
        load_ir(16'h8130);
        data_in = 16'hA139;
        ir_enable = 1'b1;
        write_reg_enable = 1'b1;
        c_sel = 1'b0;
        step();
        ir_enable = 1'b0;
        write_reg_enable = 1'b0;
        check("new decode after edge", decoded, D_ADD);
        read_reg(2'd1, rd); check("write by old decode", rd, 16'hA139);

        // Simultaneous PC branch and IR load uses the old target
        load_ir(16'h0107);
        data_in = 16'hFF00;
        ir_enable = 1'b1;
        pc_enable = 1'b1;
        branch = 1'b1;
        step();
        {ir_enable, pc_enable, branch} = '0;
        check("branch old target", ram_addr, 5'h07);
        check("halt decode", decoded, D_HALT);

        // Mid-cycle asynchronous reset after activity
        load_reg(2'd0, 16'h1234);
        load_ir(16'h8200);
        check("pre-reset data_out", data_out, 16'h1234);
        data_in = 16'hFFFF;
        {pc_enable, ir_enable, write_reg_enable, flags_reg_enable} = 4'b1111;
        #2;
        rst = 1'b1;
        #1;
        check("async rst ram_addr", ram_addr, 5'h00);
        check("async rst data_out", data_out, 16'h0000);
        check("async rst decode", decoded, D_NOP);
        check("async rst flags", flags(), 4'b0000);
        step();
        check("rst held decode", decoded, D_NOP);
        check("rst held pc", ram_addr, 5'h00);
        rst = 1'b0;
        {ir_enable, write_reg_enable, flags_reg_enable} = 3'b000;
        step();
        check("first pc after rst", ram_addr, 5'h01);
        pc_enable = 1'b0;
        for (int r = 0; r < 4; r++) begin
            read_reg(2'(r), rd);
            check($sformatf("reg %0d after rst", r), rd, 16'h0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
